// File: rtl/lfsr_noise_bank.sv
// Bank of CHANNELS independent Fibonacci LFSRs producing N fresh bits per channel
// per sample, presented over a valid/ready handshake that never drops or repeats.
module lfsr_noise_bank #(
    parameter int unsigned           N          = 8,
    parameter int unsigned           LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
    parameter int unsigned           CHANNELS   = 1,
    parameter logic [LFSR_WIDTH-1:0] SEED       = '1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_in,
    input  logic                  seed_valid_in,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [CHANNELS*N-1:0] noise_out
);

    localparam int unsigned          CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]     LAST   = CNT_W'(N - 1);
    localparam logic [31:0]          GOLDEN = 32'h9E3779B9;

    typedef enum logic {
        FILL,
        STALL
    } state_e;

    // Per-channel decorrelation: mix the channel index in with the golden-ratio
    // constant, then substitute 1 for zero so no LFSR can lock up.
    function automatic logic [LFSR_WIDTH-1:0] derive_seed(input logic [LFSR_WIDTH-1:0] s,
                                                          input int unsigned           c);
        logic [31:0]           mix;
        logic [LFSR_WIDTH-1:0] d;
        mix = c * GOLDEN;
        d   = s ^ mix[LFSR_WIDTH-1:0];
        return (d == '0) ? LFSR_WIDTH'(1) : d;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] shift(input logic [LFSR_WIDTH-1:0] l);
        return {l[LFSR_WIDTH-2:0], ^(l & TAPS)};
    endfunction

    logic [LFSR_WIDTH-1:0] lfsr_q [CHANNELS];
    logic [LFSR_WIDTH-1:0] lfsr_d [CHANNELS];
    logic [CHANNELS*N-1:0] sample_d;
    logic [CHANNELS*N-1:0] noise_q;
    logic [CHANNELS*N-1:0] held_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  valid_q;
    state_e                state_q;

    always_comb begin
        // NOTE: default before the loop so no bit of sample_d can infer a latch.
        sample_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            lfsr_d[c]            = shift(lfsr_q[c]);
            sample_d[c*N +: N]   = lfsr_d[c][N-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: the LFSR array is a small register bank, not a RAM, so it takes a reset value.
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                lfsr_q[c] <= derive_seed(SEED, c);
            end
            cnt_q   <= '0;
            state_q <= FILL;
            valid_q <= 1'b0;
            noise_q <= '0;
            held_q  <= '0;
        end else if (seed_valid_in) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                lfsr_q[c] <= derive_seed(seed_in, c);
            end
            cnt_q   <= '0;
            state_q <= FILL;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values of the others.
            if (valid_q && ready_in) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                FILL: begin
                    if (en_in) begin
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            lfsr_q[c] <= lfsr_d[c];
                        end
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            if (!valid_q || ready_in) begin
                                noise_q <= sample_d;
                                valid_q <= 1'b1;
                            end else begin
                                held_q  <= sample_d;
                                state_q <= STALL;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                STALL: begin
                    // Exit on the transfer even when gated, otherwise valid would drop
                    // with a held sample and nothing could ever release it.
                    if (ready_in) begin
                        noise_q <= held_q;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign valid_out = valid_q;
    assign noise_out = noise_q;

endmodule

// File: tb/tb_lfsr_noise_bank.sv
// Directed bench for lfsr_noise_bank: single-channel sequences, seed load, stall,
// async reset, enable gating, and a four-channel instance checked against a model.
module tb_lfsr_noise_bank;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        en_in;
    logic        seed_valid_in;
    logic [15:0] seed_in;
    logic        ready_in;
    logic        valid1;
    logic [7:0]  noise1;
    logic        valid4;
    logic [31:0] noise4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    lfsr_noise_bank dut1 (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .en_in         (en_in),
        .seed_valid_in (seed_valid_in),
        .seed_in       (seed_in),
        .ready_in      (ready_in),
        .valid_out     (valid1),
        .noise_out     (noise1)
    );

    lfsr_noise_bank #(.CHANNELS(4)) dut4 (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .en_in         (en_in),
        .seed_valid_in (seed_valid_in),
        .seed_in       (seed_in),
        .ready_in      (ready_in),
        .valid_out     (valid4),
        .noise_out     (noise4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Called one time unit after an edge; the next edge is edge 1 after release.
    task automatic do_reset();
        rst_n_in = 1'b0;
        step();
        rst_n_in = 1'b1;
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [15:0] m   [4];
    logic [7:0]  smp [4][64];

    initial begin
        rst_n_in      = 1'b0;
        en_in         = 1'b1;
        seed_valid_in = 1'b0;
        seed_in       = 16'h0000;
        ready_in      = 1'b1;

        // Reset state and free-running single-channel sequence
        #1;
        check("reset_valid", 32'(valid1), 32'd0);
        check("reset_noise", 32'(noise1), 32'h00);
        step();
        rst_n_in = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check("run_valid", 32'(valid1), 32'((k == 8) || (k == 16) || (k == 24)));
            if (k == 8)  check("run_s0", 32'(noise1), 32'h00);
            if (k == 16) check("run_s1", 32'(noise1), 32'h1B);
            if (k == 24) check("run_s2", 32'(noise1), 32'h03);
        end

        // Seed load of zero discards the presented sample even with ready high
        seed_in       = 16'h0000;
        seed_valid_in = 1'b1;
        step();
        seed_valid_in = 1'b0;
        check("load_valid_cleared", 32'(valid1), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("load_valid", 32'(valid1), 32'((k == 8) || (k == 16)));
            if (k == 8)  check("load_s0", 32'(noise1), 32'h00);
            if (k == 16) check("load_s1", 32'(noise1), 32'h2D);
        end

        // Backpressure: present, hold, stall, then release
        ready_in = 1'b0;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step();
            check("stall_valid", 32'(valid1), 32'(k >= 8));
            if (k >= 8) check("stall_hold", 32'(noise1), 32'h00);
        end
        ready_in = 1'b1;
        step();
        check("stall_exit_valid", 32'(valid1), 32'd1);
        check("stall_exit_noise", 32'(noise1), 32'h1B);
        for (int k = 32; k <= 39; k++) begin
            step();
            check("post_stall_valid", 32'(valid1), 32'(k == 39));
        end
        check("post_stall_s2", 32'(noise1), 32'h03);

        // Asynchronous reset in the middle of a stall
        ready_in = 1'b0;
        do_reset();
        for (int k = 1; k <= 20; k++) step();
        check("pre_areset_valid", 32'(valid1), 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("areset_valid", 32'(valid1), 32'd0);
        check("areset_noise", 32'(noise1), 32'h00);
        ready_in = 1'b1;
        step();
        rst_n_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("areset_restart_valid", 32'(valid1), 32'(k == 8));
        end
        check("areset_restart_s0", 32'(noise1), 32'h00);

        // Enable toggled every cycle: same samples at twice the period
        en_in = 1'b0;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            en_in = (k % 2 == 0);
            step();
            check("gated_valid", 32'(valid1), 32'((k == 16) || (k == 32)));
            if (k == 16) check("gated_s0", 32'(noise1), 32'h00);
            if (k == 32) check("gated_s1", 32'(noise1), 32'h1B);
        end

        // Four-channel instance against a reference model seeded by hand
        en_in = 1'b1;
        do_reset();
        m[0] = 16'hFFFF;
        m[1] = 16'h8646;
        m[2] = 16'h0C8D;
        m[3] = 16'h92D4;
        for (int s = 0; s < 64; s++) begin
            for (int b = 0; b < 8; b++) begin
                step();
                for (int ch = 0; ch < 4; ch++) m[ch] = ref_step(m[ch]);
                if (b == 0) check("ch4_valid_low", 32'(valid4), 32'd0);
            end
            check("ch4_valid_high", 32'(valid4), 32'd1);
            for (int ch = 0; ch < 4; ch++) begin
                smp[ch][s] = noise4[ch*8 +: 8];
                check($sformatf("ch4_c%0d_s%0d", ch, s), 32'(smp[ch][s]), 32'(m[ch][7:0]));
            end
        end
        check("ch4_c0_s0", 32'(smp[0][0]), 32'h00);
        check("ch4_c0_s1", 32'(smp[0][1]), 32'h1B);
        for (int a = 0; a < 4; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                int same;
                same = 0;
                for (int s = 0; s < 64; s++) if (smp[a][s] == smp[b][s]) same++;
                check($sformatf("ch4_distinct_%0d_%0d", a, b), 32'(same < 64), 32'd1);
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            int run;
            int max_run;
            run     = 0;
            max_run = 0;
            for (int s = 0; s < 64; s++) begin
                for (int i = 7; i >= 0; i--) begin
                    run = smp[ch][s][i] ? 0 : run + 1;
                    if (run > max_run) max_run = run;
                end
            end
            check($sformatf("ch4_zero_run_c%0d", ch), 32'(max_run < 16), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
